// File: rtl/banked_genblock_mem_pkg.sv
// Shared types and helpers for the banked memory block:
// copy-engine FSM states and the index-width helper.
package banked_genblock_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } cp_state_e;

    // One-entry or one-bank builds still need a 1-bit index.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One DEPTH x DW storage bank: synchronous clear, one write port,
// whole contents exposed combinationally for the read/copy muxes.
module mem_bank #(
    parameter int DEPTH  = 8,
    parameter int DW     = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DW-1:0]     i_wdata,
    output logic [DW-1:0]     o_mem [DEPTH]
);

    logic [DW-1:0] r_mem [DEPTH];

    // NOTE: the storage array is cleared by reset because the block
    // promises all-zero contents afterwards; this keeps it in flops, not RAM.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_mem = r_mem;

endmodule

// File: rtl/banked_genblock_mem.sv
// NUM_BANKS independent banks with a write demux, a registered read mux
// and a bank-to-bank copy engine; bank 0 is exported live.
module banked_genblock_mem
    import banked_genblock_mem_pkg::*;
#(
    parameter  int NUM_BANKS = 4,
    parameter  int DEPTH     = 8,
    parameter  int DW        = 32,
    localparam int ADDR_W    = width_of(DEPTH),
    localparam int BANK_W    = width_of(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              wr_drop,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    input  logic              cp_start,
    input  logic [BANK_W-1:0] cp_src,
    input  logic [BANK_W-1:0] cp_dst,
    output logic              cp_busy,
    output logic              cp_done,
    output logic [DW-1:0]     bank0_o [DEPTH]
);

    cp_state_e         r_state;
    cp_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [BANK_W-1:0] r_src;
    logic [BANK_W-1:0] r_dst;
    logic              r_rd_valid;
    logic [DW-1:0]     r_rd_data;
    logic              r_wr_drop;

    logic [DW-1:0]        w_bank_data [NUM_BANKS][DEPTH];
    logic [NUM_BANKS-1:0] w_we;
    logic [ADDR_W-1:0]    w_waddr [NUM_BANKS];
    logic [DW-1:0]        w_wdata [NUM_BANKS];
    logic [DW-1:0]        w_rd_word;
    logic [DW-1:0]        w_cp_word;
    logic                 w_wr_ok;
    logic                 w_wr_hits_dst;
    logic                 w_cp_ok;

    assign w_wr_ok       = wr_en && (int'(wr_bank) < NUM_BANKS) && (int'(wr_addr) < DEPTH);
    assign w_wr_hits_dst = (r_state == COPY) && (wr_bank == r_dst);
    assign w_cp_ok       = (int'(cp_src) < NUM_BANKS) && (int'(cp_dst) < NUM_BANKS);

    // NOTE: every always_comb output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if ((int'(rd_bank) == b) && (int'(rd_addr) < DEPTH)) begin
                w_rd_word = w_bank_data[b][rd_addr];
            end
        end
    end

    // Copy data comes from pre-edge storage, so a same-cycle write to
    // src[counter] is not seen by the copy.
    always_comb begin
        w_cp_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(r_src) == b) begin
                w_cp_word = w_bank_data[b][r_cnt];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_we[b]    = 1'b0;
            w_waddr[b] = wr_addr;
            w_wdata[b] = wr_data;
            if ((r_state == COPY) && (int'(r_dst) == b)) begin
                w_we[b]    = 1'b1;
                w_waddr[b] = r_cnt;
                w_wdata[b] = w_cp_word;
            end else if (w_wr_ok && !w_wr_hits_dst && (int'(wr_bank) == b)) begin
                w_we[b] = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gen_banks
        mem_bank #(
            .DEPTH  (DEPTH),
            .DW     (DW),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .i_rst   (rst),
            .i_we    (w_we[b]),
            .i_waddr (w_waddr[b]),
            .i_wdata (w_wdata[b]),
            .o_mem   (w_bank_data[b])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cp_start && w_cp_ok) w_state_nxt = COPY;
            COPY:    if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && (w_state_nxt == COPY)) begin
                r_cnt <= '0;
                r_src <= cp_src;
                r_dst <= cp_dst;
            end else if (r_state == COPY) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
            r_wr_drop <= w_wr_ok && w_wr_hits_dst;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign wr_drop  = r_wr_drop;
    assign cp_busy  = (r_state == COPY);
    assign cp_done  = (r_state == DONE);
    assign bank0_o  = w_bank_data[0];

endmodule

// File: tb/tb_banked_genblock_mem.sv
// Scoreboarded bench for banked_genblock_mem: a 4-bank main instance plus
// a 3-bank instance for out-of-range bank handling.
module tb_banked_genblock_mem;

    localparam int NB    = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, cp_start;
    logic [1:0]    wr_bank, rd_bank, cp_src, cp_dst;
    logic [2:0]    wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_drop, rd_valid, cp_busy, cp_done;
    logic [DW-1:0] bank0_o [DEPTH];

    logic          d3_wr_en, d3_rd_en, d3_cp_start;
    logic [1:0]    d3_wr_bank, d3_rd_bank, d3_cp_src, d3_cp_dst;
    logic [2:0]    d3_wr_addr, d3_rd_addr;
    logic [DW-1:0] d3_wr_data, d3_rd_data;
    logic          d3_wr_drop, d3_rd_valid, d3_cp_busy, d3_cp_done;
    logic [DW-1:0] d3_bank0_o [DEPTH];

    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] model [NB][DEPTH];
    logic [DW-1:0] rd_q [$];

    always #5 clk = ~clk;

    banked_genblock_mem #(.NUM_BANKS(NB), .DEPTH(DEPTH), .DW(DW)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .cp_start(cp_start), .cp_src(cp_src), .cp_dst(cp_dst), .cp_busy(cp_busy), .cp_done(cp_done),
        .bank0_o(bank0_o)
    );

    banked_genblock_mem #(.NUM_BANKS(3), .DEPTH(DEPTH), .DW(DW)) u_dut3 (
        .clk(clk), .rst(rst),
        .wr_en(d3_wr_en), .wr_bank(d3_wr_bank), .wr_addr(d3_wr_addr), .wr_data(d3_wr_data),
        .wr_drop(d3_wr_drop),
        .rd_en(d3_rd_en), .rd_bank(d3_rd_bank), .rd_addr(d3_rd_addr), .rd_valid(d3_rd_valid),
        .rd_data(d3_rd_data),
        .cp_start(d3_cp_start), .cp_src(d3_cp_src), .cp_dst(d3_cp_dst), .cp_busy(d3_cp_busy),
        .cp_done(d3_cp_done),
        .bank0_o(d3_bank0_o)
    );

    // Read scoreboard: every returned read word is matched against the
    // value queued when the read was issued.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            n_total++;
            if (rd_q.size() == 0) begin
                $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding, rd_data=%h", rd_data);
            end else begin
                automatic logic [DW-1:0] exp = rd_q.pop_front();
                if (rd_data !== exp) $display("FAIL rd_data: got %h expected %h", rd_data, exp);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input int b, input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_bank = 2'(b); wr_addr = 3'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        model[b][a] = d;
    endtask

    task automatic issue_read(input int b, input int a);
        rd_en = 1'b1; rd_bank = 2'(b); rd_addr = 3'(a);
        rd_q.push_back(model[b][a]);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic start_copy(input int s, input int d);
        cp_start = 1'b1; cp_src = 2'(s); cp_dst = 2'(d);
        tick();
        cp_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (cp_done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_total++;
        if (cp_done !== 1'b1) $display("FAIL %s_timeout: cp_done=%b expected 1 within 20 cycles", tag, cp_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) model[b][a] = '0;
        n_total++;
        if ({cp_busy, cp_done, wr_drop, rd_valid} !== 4'b0000)
            $display("FAIL reset_flags: busy/done/drop/valid=%b expected 0000", {cp_busy, cp_done, wr_drop, rd_valid});
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) if (bank0_o[a] !== '0) bad++;
        n_total++;
        if (bad != 0) $display("FAIL reset_bank0: %0d nonzero entries expected 0", bad);
        else n_pass++;
        issue_read(2, 5);
        n_total++;
        if (rd_valid !== 1'b1) $display("FAIL reset_rd_valid: got %b expected 1", rd_valid);
        else n_pass++;
    endtask

    task automatic test_write_read();
        issue_write(1, 3, 32'hDEADBEEF);
        issue_read(1, 3);
        // Same-cycle read and write of one entry returns the old word.
        wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 3'd3; wr_data = 32'h1;
        rd_en = 1'b1; rd_bank = 2'd1; rd_addr = 3'd3;
        rd_q.push_back(model[1][3]);
        model[1][3] = 32'h1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        issue_read(1, 3);
        tick();
        n_total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h1)
            $display("FAIL rd_hold: valid=%b data=%h expected valid=0 data=00000001", rd_valid, rd_data);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            automatic int b = $urandom_range(0, NB - 1);
            automatic int a = $urandom_range(0, DEPTH - 1);
            issue_write(b, a, $urandom);
            issue_read(b, a);
        end
    endtask

    task automatic test_copy();
        int busy_cnt = 0;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) issue_write(0, i, 32'h10 + i);
        for (int a = 0; a < DEPTH; a++) if (bank0_o[a] !== model[0][a]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL bank0_o_fill: %0d entries differ from 0x10+i", bad);
        else n_pass++;
        start_copy(0, 3);
        for (int k = 0; k < DEPTH; k++) begin
            if (cp_busy === 1'b1 && cp_done === 1'b0) busy_cnt++;
            tick();
        end
        n_total++;
        if (busy_cnt != DEPTH) $display("FAIL copy_busy_cycles: got %0d expected %0d", busy_cnt, DEPTH);
        else n_pass++;
        n_total++;
        if (cp_done !== 1'b1 || cp_busy !== 1'b0)
            $display("FAIL copy_done_T9: done=%b busy=%b expected done=1 busy=0", cp_done, cp_busy);
        else n_pass++;
        tick();
        n_total++;
        if (cp_done !== 1'b0) $display("FAIL copy_done_pulse: got %b expected 0", cp_done);
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) model[3][a] = model[0][a];
        for (int a = 0; a < DEPTH; a++) issue_read(3, a);
    endtask

    task automatic test_copy_interaction();
        logic [DW-1:0] exp3 [DEPTH];
        for (int i = 0; i < DEPTH; i++) issue_write(0, i, 32'h20 + i);
        for (int i = 0; i < DEPTH; i++) exp3[i] = model[0][i];
        exp3[7] = 32'h99;
        start_copy(0, 3);
        wr_en = 1'b1; wr_bank = 2'd3; wr_addr = 3'd0; wr_data = 32'hBAD;
        tick();
        wr_en = 1'b0;
        n_total++;
        if (wr_drop !== 1'b1) $display("FAIL wr_drop_dst: got %b expected 1", wr_drop);
        else n_pass++;
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 3'd7; wr_data = 32'h99;
        tick();
        wr_en = 1'b0;
        n_total++;
        if (wr_drop !== 1'b0) $display("FAIL wr_drop_src: got %b expected 0", wr_drop);
        else n_pass++;
        tick();
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 3'd3; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        model[0][7] = 32'h99;
        model[0][3] = 32'h77;
        wait_done("interact");
        for (int a = 0; a < DEPTH; a++) model[3][a] = exp3[a];
        for (int a = 0; a < DEPTH; a++) issue_read(3, a);
        issue_read(0, 3);
        issue_read(0, 7);
    endtask

    task automatic test_reset_mid_copy();
        int seen = 0;
        int bad  = 0;
        start_copy(0, 3);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) model[b][a] = '0;
        n_total++;
        if (cp_busy !== 1'b0 || cp_done !== 1'b0)
            $display("FAIL midcopy_reset_state: busy=%b done=%b expected 0 0", cp_busy, cp_done);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            if (cp_done === 1'b1 || cp_busy === 1'b1) seen++;
            tick();
        end
        n_total++;
        if (seen != 0) $display("FAIL midcopy_no_done: %0d busy/done cycles expected 0", seen);
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) if (bank0_o[a] !== '0) bad++;
        n_total++;
        if (bad != 0) $display("FAIL midcopy_bank0_clear: %0d nonzero entries expected 0", bad);
        else n_pass++;
        issue_read(3, 0);
        issue_read(3, 7);
        issue_read(1, 3);
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int k = 0;
        issue_write(1, 3, 32'hABC);
        start_copy(1, 2);
        // Start request for 0->1 while copying must be ignored.
        cp_start = 1'b1; cp_src = 2'd0; cp_dst = 2'd1;
        while (cp_done !== 1'b1 && k < 20) begin
            if (cp_busy === 1'b1) busy_cnt++;
            tick();
            cp_start = 1'b0;
            k++;
        end
        n_total++;
        if (busy_cnt != DEPTH || cp_done !== 1'b1)
            $display("FAIL busy_start_ignored: busy_cycles=%0d done=%b expected %0d 1", busy_cnt, cp_done, DEPTH);
        else n_pass++;
        for (int a = 0; a < DEPTH; a++) model[2][a] = model[1][a];
        cp_start = 1'b1; cp_src = 2'd2; cp_dst = 2'd2;
        tick();
        n_total++;
        if (cp_busy !== 1'b0) $display("FAIL done_start_ignored: busy=%b expected 0", cp_busy);
        else n_pass++;
        tick();
        cp_start = 1'b0;
        n_total++;
        if (cp_busy !== 1'b1) $display("FAIL earliest_restart: busy=%b expected 1", cp_busy);
        else n_pass++;
        wr_en = 1'b1; wr_bank = 2'd2; wr_addr = 3'd3; wr_data = 32'hEEE;
        tick();
        wr_en = 1'b0;
        wait_done("self_copy");
        tick();
        issue_read(2, 3);
        issue_read(1, 3);
        issue_read(0, 3);
    endtask

    task automatic test_bank_range();
        d3_cp_start = 1'b1; d3_cp_src = 2'd0; d3_cp_dst = 2'd3;
        tick();
        d3_cp_start = 1'b1; d3_cp_src = 2'd3; d3_cp_dst = 2'd0;
        tick();
        d3_cp_start = 1'b0;
        n_total++;
        if (d3_cp_busy !== 1'b0 || d3_cp_done !== 1'b0)
            $display("FAIL range_cp_ignored: busy=%b done=%b expected 0 0", d3_cp_busy, d3_cp_done);
        else n_pass++;
        d3_wr_en = 1'b1; d3_wr_bank = 2'd3; d3_wr_addr = 3'd1; d3_wr_data = 32'h5A5A;
        tick();
        d3_wr_en = 1'b1; d3_wr_bank = 2'd2; d3_wr_addr = 3'd1; d3_wr_data = 32'h42;
        n_total++;
        if (d3_wr_drop !== 1'b0) $display("FAIL range_wr_drop: got %b expected 0", d3_wr_drop);
        else n_pass++;
        tick();
        d3_wr_en = 1'b0;
        d3_rd_en = 1'b1; d3_rd_bank = 2'd3; d3_rd_addr = 3'd1;
        tick();
        n_total++;
        if (d3_rd_valid !== 1'b1 || d3_rd_data !== '0)
            $display("FAIL range_rd: valid=%b data=%h expected 1 00000000", d3_rd_valid, d3_rd_data);
        else n_pass++;
        d3_rd_bank = 2'd2;
        tick();
        d3_rd_en = 1'b0;
        n_total++;
        if (d3_rd_valid !== 1'b1 || d3_rd_data !== 32'h42)
            $display("FAIL range_inbank_rd: valid=%b data=%h expected 1 00000042", d3_rd_valid, d3_rd_data);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
        cp_start = 1'b0; cp_src = '0; cp_dst = '0;
        d3_wr_en = 1'b0; d3_wr_bank = '0; d3_wr_addr = '0; d3_wr_data = '0;
        d3_rd_en = 1'b0; d3_rd_bank = '0; d3_rd_addr = '0;
        d3_cp_start = 1'b0; d3_cp_src = '0; d3_cp_dst = '0;
        test_reset();
        test_write_read();
        test_copy();
        test_copy_interaction();
        test_reset_mid_copy();
        test_back_to_back();
        test_bank_range();
        tick(); tick();
        n_total++;
        if (rd_q.size() != 0) $display("FAIL rd_outstanding: %0d reads never returned expected 0", rd_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/banked_genblock_mem.md
# banked_genblock_mem

Multi-bank storage block that generalises nested-generate unpacked-array memories into a parametrised, clocked structure. It instantiates NUM_BANKS independent DEPTH x DW banks inside a generate loop and provides one write port, one registered read port, and a bank-to-bank copy engine driven by a small state machine. Bank 0 contents are exported as an unpacked array port. The block serves as a frontend regression target for generate-scoped memories, unpacked-array assignments and FSMs.

## Interface
Parameters:
- NUM_BANKS, 4, number of banks (>= 1)
- DEPTH, 8, entries per bank (>= 2)
- DW, 32, data width in bits (>= 1)

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  write request
- wr_bank  input  BANK_W  target bank of the write
- wr_addr  input  ADDR_W  target entry of the write
- wr_data  input  DW  write data
- wr_drop  output  1  pulses one cycle when an accepted write is discarded
- rd_en  input  1  read request
- rd_bank  input  BANK_W  source bank of the read
- rd_addr  input  ADDR_W  source entry of the read
- rd_valid  output  1  read data valid
- rd_data  output  DW  read data
- cp_start  input  1  start a bank copy
- cp_src  input  BANK_W  copy source bank
- cp_dst  input  BANK_W  copy destination bank
- cp_busy  output  1  copy in progress
- cp_done  output  1  one-cycle pulse when a copy finishes
- bank0_o  output  [DW-1:0] x [DEPTH] (unpacked)  live contents of bank 0

Derived widths: ADDR_W = max(1, $clog2(DEPTH)); BANK_W = max(1, $clog2(NUM_BANKS)).

## Operation
- Reset: rst=1 at a rising edge clears every entry of every bank to 0. It also sets FSM=IDLE, rd_valid=0, rd_data=0, wr_drop=0, cp_busy=0 and cp_done=0. Reset mid-copy aborts the copy with no cp_done.
- Write: when wr_en=1 and wr_bank<NUM_BANKS and wr_addr<DEPTH, the entry is updated at the edge. Out-of-range bank or address: the write is ignored and wr_drop stays 0.
- Write during copy: a write targeting cp_dst while FSM=COPY is discarded and wr_drop=1 on the next cycle. Writes to any other bank proceed, including writes to the source bank.
- Read: rd_en=1 registers rd_data and sets rd_valid=1 on the next cycle. An out-of-range bank or address returns 0 with rd_valid=1. When rd_en=0, rd_valid=0 and rd_data holds its last value. A read and a write to the same entry in the same cycle return the old data.
- Copy FSM states:
  - IDLE: cp_start=1 with both banks in range → COPY, counter=0. cp_start with either bank out of range is ignored. cp_start is ignored in COPY and DONE.
  - COPY: each cycle, dst[counter] <= src[counter] and counter increments. After entry DEPTH-1 → DONE. cp_src and cp_dst are latched at start.
  - DONE: cp_done=1 for one cycle → IDLE.
- Copy/write interaction: copy reads use pre-edge values. A same-cycle write to src[counter] is not copied. A write to a src entry not yet reached is copied.
- src==dst: the copy runs its full length and leaves contents unchanged.
- bank0_o is driven combinationally from bank 0 storage.

## Timing
- cp_start accepted at edge T. cp_busy=1 during cycles T+1..T+DEPTH. Entry i is written at edge T+1+i.
- cp_done=1 in cycle T+DEPTH+1, with cp_busy=0 in that cycle. The earliest next accepted cp_start is at edge T+DEPTH+2.
- Read latency is 1 cycle. wr_drop latency is 1 cycle.
- bank0_o reflects a write one cycle after the write edge (after the storage update).

## Structure
- Package banked_genblock_mem_pkg holds the FSM enum (IDLE, COPY, DONE) and a width helper function returning max(1, $clog2(n)).
- Sub-module mem_bank holds one DEPTH x DW unpacked array with a sync-reset clear, one write port and a combinational read port. It is instantiated NUM_BANKS times in a named generate loop gen_banks.
- The top level contains the write demux, the registered read mux, the FSM and the counter.

## Test plan
- Reset then read bank 2, addr 5 → rd_valid=1 next cycle, rd_data=0. bank0_o is all zeros.
- Write 0xDEADBEEF to bank 1 addr 3, then read it → 0xDEADBEEF after 1 cycle. A same-cycle read+write of bank 1 addr 3 with 0x1 → returns 0xDEADBEEF.
- Fill bank 0 with values 0x10+i, then copy 0→3 → cp_busy high for 8 cycles, cp_done pulses at T+9, and bank 3 reads back 0x10..0x17.
- During a 0→3 copy, write bank 3 addr 0 → wr_drop=1 next cycle and the entry ends as 0x10. Writing bank 0 addr 7 with 0x99 before the counter reaches 7 → bank 3 addr 7 = 0x99.
- Assert rst at cycle T+4 of a copy → the FSM returns to IDLE, no cp_done, and all banks are zero.
- cp_start while busy, or with cp_dst=NUM_BANKS (NUM_BANKS=3 build) → ignored, cp_busy unchanged.
